// File: rtl/riscm_ctrl_pkg.sv
// riscm_ctrl_pkg: shared state/class encodings and opcode constants for the instruction sequencer
package riscm_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECODE   = 3'd1,
        EXEC     = 3'd2,
        MEM_WAIT = 3'd3,
        WB       = 3'd4,
        ERR      = 3'd5
    } state_t;
    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_BR
    } cls_t;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b110;
endpackage

// File: rtl/instr_sequencer_opcode_classifier.sv
// opcode_classifier: maps a 3-bit opcode to its execution class and store flag
module opcode_classifier
    import riscm_ctrl_pkg::*;
(
    input  logic [2:0] i_op,
    output cls_t       o_cls,
    output logic       o_is_store
);
    // memory opcodes first, then the three branch encodings; everything else is ALU
    always_comb begin
        o_cls      = (i_op == OP_LOAD || i_op == OP_STORE) ? CLS_MEM :
                     (i_op == 3'b000 || i_op == 3'b100 || i_op == 3'b111) ? CLS_BR : CLS_ALU;
        o_is_store = i_op == OP_STORE;
    end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM sequencing ALU, memory, write-back and PC update
module instr_sequencer
    import riscm_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_instr_valid,
    output logic             o_instr_ready,
    input  logic [15:0]      i_instr,
    input  logic             i_branch_taken,
    input  logic             i_mem_done,
    input  logic             i_err_clr,
    output logic             o_alu_en,
    output logic             o_branch_en,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_reg_we,
    output logic             o_pc_inc,
    output logic             o_pc_load,
    output logic [15:0]      o_ir,
    output logic             o_busy,
    output logic             o_err,
    output logic [CNT_W-1:0] o_instr_count
);
    localparam int TW = $clog2(MEM_TIMEOUT) + 1;
    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_ir;
    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_count;
    logic             r_taken;
    logic             r_st_done;
    cls_t             w_cls;
    logic             w_is_store;
    logic             w_timeout;
    logic             w_retire;

    opcode_classifier u_cls (
        .i_op       (r_ir[15:13]),
        .o_cls      (w_cls),
        .o_is_store (w_is_store)
    );

    assign w_timeout = r_timer == TW'(MEM_TIMEOUT - 1);
    assign w_retire  = (r_state == EXEC && w_cls == CLS_BR) || r_state == WB ||
                       (r_state == MEM_WAIT && i_mem_done && w_is_store);

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // next-state logic; mem_done takes priority over the timeout in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = i_instr_valid ? DECODE : IDLE;
            DECODE:   w_next = (w_cls == CLS_MEM) ? MEM_WAIT : EXEC;
            EXEC:     w_next = (w_cls == CLS_ALU) ? WB : IDLE;
            MEM_WAIT: w_next = i_mem_done ? (w_is_store ? IDLE : WB) : w_timeout ? ERR : MEM_WAIT;
            WB:       w_next = IDLE;
            ERR:      w_next = i_err_clr ? IDLE : ERR;
            default:  w_next = IDLE;
        endcase
    end

    // datapath registers: instruction latch, memory timer, retire counter and registered PC strobes
    // branch_taken is captured as EXEC is entered so pc_load/pc_inc come from flops during EXEC
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ir      <= '0;
            r_timer   <= '0;
            r_count   <= '0;
            r_taken   <= 1'b0;
            r_st_done <= 1'b0;
        end else begin
            r_ir      <= (r_state == IDLE && i_instr_valid) ? i_instr : r_ir;
            r_timer   <= (r_state == MEM_WAIT) ? r_timer + 1'b1 : '0;
            r_count   <= w_retire ? r_count + 1'b1 : r_count;
            r_taken   <= (r_state == DECODE) ? i_branch_taken : r_taken;
            r_st_done <= r_state == MEM_WAIT && i_mem_done && w_is_store;
        end
    end

    // outputs decoded from registered state only
    always_comb begin
        o_instr_ready = r_state == IDLE;
        o_busy        = r_state != IDLE;
        o_alu_en      = r_state == EXEC && w_cls == CLS_ALU;
        o_branch_en   = r_state == EXEC && w_cls == CLS_BR;
        o_mem_req     = r_state == MEM_WAIT;
        o_mem_we      = r_state == MEM_WAIT && w_is_store;
        o_reg_we      = r_state == WB;
        o_pc_load     = o_branch_en && r_taken;
        o_pc_inc      = r_state == WB || (o_branch_en && !r_taken) || r_st_done;
        o_err         = r_state == ERR;
        o_ir          = r_ir;
        o_instr_count = r_count;
    end
endmodule
